// File: rtl/nrisc_wb_stage_pkg.sv
// Shared NRISC register-file constants and writeback-stage types.
// Holds the register-file index constants, the port-select enum and the index filter.
package nrisc_wb_stage_pkg;

  localparam int NRISC_TAM = 16;
  localparam int REG_IDX_W = 4;

  localparam logic [REG_IDX_W-1:0] REG_ZERO        = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_EXT_R1      = 4'd1;
  localparam logic [REG_IDX_W-1:0] NRISC_BANK_BASE = 4'd8;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_FIFO,
    SEL_BYPASS
  } wb_sel_e;

  // R0 is constant and R1 is driven from outside, so neither may be written here.
  function automatic logic rf_writable(input logic [REG_IDX_W-1:0] idx);
    return (idx != REG_ZERO) && (idx != REG_EXT_R1);
  endfunction

endpackage

// File: rtl/nrisc_wb_fifo.sv
// In-order load-result FIFO for the NRISC writeback stage.
// Exposes per-entry valid bits and destination indices so the top can do hazard compares.
module nrisc_wb_fifo
  import nrisc_wb_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = NRISC_TAM + REG_IDX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CNT_W-1:0]           count_o,
  output logic [DEPTH-1:0]           ent_valid_o,
  output logic [DEPTH*REG_IDX_W-1:0] ent_rfd_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: the storage array has no reset; an entry is only meaningful while the pointers/count mark it valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // An entry is live when its distance from the read pointer (mod DEPTH) is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
      ent_rfd_o[i*REG_IDX_W +: REG_IDX_W] = mem_q[i][W-1 -: REG_IDX_W];
    end
  end

endmodule

// File: rtl/nrisc_wb_stage.sv
// NRISC writeback stage: merges ALU and load results onto the single register-file write port.
// ALU has priority; loads queue in a FIFO, with a starvation throttle and pending-write hazard flags.
module nrisc_wb_stage
  import nrisc_wb_stage_pkg::*;
#(
  parameter int TAM        = NRISC_TAM,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rfd,
  input  logic [TAM-1:0]       alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_rfd,
  input  logic [TAM-1:0]       mem_data,
  output logic [TAM-1:0]       REG_D,
  output logic [REG_IDX_W-1:0] REG_RFD,
  output logic                 REG_Write,
  input  logic [REG_IDX_W-1:0] hz_rf1,
  input  logic [REG_IDX_W-1:0] hz_rf2,
  output logic                 hz_hit1,
  output logic                 hz_hit2,
  output logic                 wb_idle
);

  localparam int FW    = TAM + REG_IDX_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  logic                 write_q;
  logic [REG_IDX_W-1:0] rfd_q;
  logic [TAM-1:0]       data_q;
  logic [SW-1:0]        starve_q, starve_d;

  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]              fifo_head;
  logic [CNT_W-1:0]           fifo_count;
  logic [DEPTH-1:0]           fifo_ent_valid;
  logic [DEPTH*REG_IDX_W-1:0] fifo_ent_rfd;

  logic    alu_take, mem_take;
  wb_sel_e sel;

  nrisc_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (fifo_push),
    .push_data_i ({mem_rfd, mem_data}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .ent_valid_o (fifo_ent_valid),
    .ent_rfd_o   (fifo_ent_rfd)
  );

  assign alu_ready = (starve_q != SW'(STARVE_MAX));
  // Gated by rst directly so loads are refused during reset yet accepted on the very first cycle after it.
  assign mem_ready = rst & (fifo_count < CNT_W'(DEPTH));

  // Results aimed at R0/R1 are still handshaken, just never selected or queued.
  assign alu_take = alu_valid & alu_ready & rf_writable(alu_rfd);
  assign mem_take = mem_valid & mem_ready & rf_writable(mem_rfd);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (alu_take)         sel = SEL_ALU;
    else if (!fifo_empty) sel = SEL_FIFO;
    else if (mem_take)    sel = SEL_BYPASS;

    fifo_pop  = (sel == SEL_FIFO);
    fifo_push = mem_take && (sel != SEL_BYPASS);

    starve_d = starve_q;
    if (fifo_empty || fifo_pop) starve_d = '0;
    else if (sel == SEL_ALU)    starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q  <= 1'b0;
      rfd_q    <= '0;
      data_q   <= '0;
      starve_q <= '0;
    end else begin
      write_q  <= (sel != SEL_NONE);
      starve_q <= starve_d;
      case (sel)
        SEL_ALU:    {rfd_q, data_q} <= {alu_rfd, alu_data};
        SEL_FIFO:   {rfd_q, data_q} <= fifo_head;
        SEL_BYPASS: {rfd_q, data_q} <= {mem_rfd, mem_data};
        default:    {rfd_q, data_q} <= {rfd_q, data_q};
      endcase
    end
  end

  assign REG_Write = write_q;
  assign REG_RFD   = rfd_q;
  assign REG_D     = data_q;
  assign wb_idle   = fifo_empty & ~write_q;

  // Hazards look only at stored state: the output register and live FIFO entries.
  always_comb begin
    hz_hit1 = write_q && (rfd_q == hz_rf1);
    hz_hit2 = write_q && (rfd_q == hz_rf2);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_ent_valid[i] && (fifo_ent_rfd[i*REG_IDX_W +: REG_IDX_W] == hz_rf1)) hz_hit1 = 1'b1;
      if (fifo_ent_valid[i] && (fifo_ent_rfd[i*REG_IDX_W +: REG_IDX_W] == hz_rf2)) hz_hit2 = 1'b1;
    end
    hz_hit1 = hz_hit1 & rf_writable(hz_rf1);
    hz_hit2 = hz_hit2 & rf_writable(hz_rf2);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(fifo_push && fifo_full));

endmodule

// File: doc/nrisc_wb_stage.md
Name: nrisc_wb_stage

Overview:
Writeback stage directly upstream of the NRISC register file. Merges ALU results and memory-load results onto the single register-file write port (REG_D / REG_RFD / REG_Write). ALU results take priority, and load results are buffered in a small FIFO. Also provides pending-write hazard flags to decode, and an idle flag for the interrupt controller, which must not toggle the bank flag while writes are pending.

Parameters:
TAM, 16, data width, equal to the register-file width
DEPTH, 4, load FIFO entries; must be a power of 2, minimum 2
STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked by the ALU before ALU intake is throttled

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
alu_valid  in  1  ALU result valid
alu_ready  out  1  stage accepts an ALU result this cycle
alu_rfd  in  4  ALU destination register index
alu_data  in  TAM  ALU result
mem_valid  in  1  load result valid
mem_ready  out  1  stage accepts a load result this cycle
mem_rfd  in  4  load destination register index
mem_data  in  TAM  load data
REG_D  out  TAM  write data to the register file
REG_RFD  out  4  write index to the register file
REG_Write  out  1  write enable to the register file
hz_rf1  in  4  decode source index 1
hz_rf2  in  4  decode source index 2
hz_hit1  out  1  a pending write targets hz_rf1
hz_hit2  out  1  a pending write targets hz_rf2
wb_idle  out  1  no pending writes (FIFO empty and REG_Write=0)

Behaviour:
- Reset (rst=0, asynchronous):
  - REG_Write=0, REG_RFD=0, REG_D=0.
  - FIFO is emptied and starve_cnt=0.
  - alu_ready=1, mem_ready=0 while reset is held, wb_idle=1.
  - In-flight entries are discarded, with no partial write.
  - After release, mem_ready=1 from the first cycle.
- Transfers occur on valid&ready. alu_ready and mem_ready depend only on registered state, never on the valid inputs.
- Index filter: any accepted result with rfd in {0,1} is accepted and silently dropped. It is never queued, never written, and never raises a hazard. R0 is constant and R1 is driven externally.
- Output register: REG_D/REG_RFD/REG_Write are registered.
  - Selection priority each cycle: (1) accepted ALU result; else (2) FIFO head, which is popped; else (3) load bypass, used only when the FIFO is empty and this cycle's load transfer selected nothing else; else REG_Write=0.
  - Latency from accept to REG_Write=1 is 1 cycle for ALU and for bypassed loads. The register file commits on the following edge.
- Load FIFO:
  - A load is pushed when it is accepted and not bypassed/dropped.
  - mem_ready = (count < DEPTH). At count==DEPTH, mem_ready=0 even if a pop occurs that cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH. Entries are written in order (no reordering among loads).
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and an accepted ALU result wins the port.
  - It clears on any FIFO pop, and when the FIFO is empty.
  - alu_ready = (starve_cnt != STARVE_MAX). When low, the FIFO head is written and starve_cnt clears, so alu_ready is low for exactly one cycle.
- Hazards:
  - hz_hitN=1 iff hz_rfN is not 0 or 1 and equals the rfd of any valid FIFO entry, or equals REG_RFD while REG_Write=1.
  - Combinational from stored state only; same-cycle inputs are not considered.
- wb_idle = FIFO empty & ~REG_Write, registered-state derived.
- Bank switching is out of scope here: the interrupt controller switches banks only while wb_idle=1.

Decomposition:
- Shared include nrisc_defs.vh holds:
  - NRISC_TAM=16
  - REG_IDX_W=4
  - REG_ZERO=0
  - REG_EXT_R1=1
  - NRISC_BANK_BASE=8 (first banked index)
- One sub-module, nrisc_wb_fifo: parameters DEPTH and width TAM+4, push/pop, full/empty/count, and a flattened entry-valid/rfd vector for hazard compare.
- The top level holds arbitration, the output register, starve_cnt and the hazard compare.

Test Plan:
- Reset mid-operation: FIFO holding 3 entries, assert rst=0 -> REG_Write=0 and REG_D=0 immediately (asynchronous), mem_ready=0. After release: wb_idle=1, mem_ready=1, no stale writes ever appear.
- ALU only: alu_rfd=5, alu_data=0x1234 at cycle N -> at N+1, REG_Write=1, REG_RFD=5, REG_D=0x1234. At N+2, REG_Write=0 and wb_idle=1.
- Simultaneous sources: ALU R3=0xAAAA and load R9=0x5555 at N -> N+1 writes R3 with hz_rf1=9 giving hz_hit1=1. N+2 writes R9=0x5555. At N+3, hz_hit1=0.
- Full FIFO and starvation (DEPTH=4, STARVE_MAX=8): continuous alu_valid, loads R10..R13 -> mem_ready=0 after the 4th push. alu_ready drops for exactly one cycle 8 cycles after the FIFO becomes non-empty, and R10 is written then. Load order R10, R11, R12, R13 is preserved.
- Dropped indices: alu_rfd=0 and mem_rfd=1, both valid -> both accepted, REG_Write stays 0, wb_idle stays 1, hz_rf1=0 gives hz_hit1=0.
- Load bypass: FIFO empty, no ALU, load R12=0xBEEF at N -> at N+1, REG_Write=1, REG_RFD=12, REG_D=0xBEEF, and the FIFO count stays 0.
